// File: rtl/addsub_pkg.sv
// Shared types and constants for the two-requester add/sub arbiter.
package addsub_pkg;
  localparam int DATA_W = 32;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/sub_add_32bit.sv
// Combinational modulo-2^32 adder/subtractor; subtract is A + ~B + 1, carry-out dropped.
module sub_add_32bit
  import addsub_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              alu_op,
  output logic [DATA_W-1:0] res
);
  logic [DATA_W-1:0] b_eff;

  assign b_eff = (alu_op == OP_SUB) ? ~b : b;
  assign res   = a + b_eff + {{(DATA_W-1){1'b0}}, alu_op};
endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath between two requesters; result at T+2, held until rsp_ready.
// Define ADDSUB_ARB_OVF_EN to add the registered signed-overflow output rsp_ovf.
module addsub_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [1:0]          req_op,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_res,
  output logic                busy
`ifdef ADDSUB_ARB_OVF_EN
  ,
  output logic                rsp_ovf
`endif
);
  import addsub_pkg::*;

  state_t            state, state_nxt;
  logic              grant, last_grant, arb_idx, op_q, xfer;
  logic [DATA_W-1:0] a_q, b_q, alu_res;

  // On a tie, favour the requester that did not win last time.
  assign arb_idx = (&req_valid) ? ~last_grant : req_valid[1];
  assign xfer    = (state == IDLE) && (|req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[grant]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (xfer)           req_ready[arb_idx] = 1'b1;
    if (state == RESP)  rsp_valid[grant]   = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
    end else if (xfer) begin
      grant      <= arb_idx;
      last_grant <= arb_idx;
      op_q       <= req_op[arb_idx];
      a_q        <= arb_idx ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
      b_q        <= arb_idx ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
    end
  end

  sub_add_32bit u_alu (
    .a      (a_q),
    .b      (b_q),
    .alu_op (op_q),
    .res    (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rsp_res <= '0;
    else if (state == EXEC)  rsp_res <= alu_res;
  end

`ifdef ADDSUB_ARB_OVF_EN
  logic ovf_nxt;

  always_comb begin
    if (op_q == OP_SUB)
      ovf_nxt = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
    else
      ovf_nxt = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rsp_ovf <= 1'b0;
    else if (state == EXEC)  rsp_ovf <= ovf_nxt;
  end
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed table, random ops against a model, multi-cycle corner sequences.
module tb_addsub_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_res;
  logic        busy;
`ifdef ADDSUB_ARB_OVF_EN
  logic        rsp_ovf;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .busy      (busy)
`ifdef ADDSUB_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp;
    logic        ovf;
    int          hold;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ovf(input string name, input logic exp);
`ifdef ADDSUB_ARB_OVF_EN
    chk(name, 32'(rsp_ovf), 32'(exp));
`else
    if (exp === 1'bx) $display("unreachable %s", name);
`endif
  endtask

  // One full command: transfer, EXEC, RESP with optional back-pressure, accept.
  task automatic run_op(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] exp, input logic eovf, input int hold);
    logic [1:0] oh;
    oh = 2'b01 << r;
    tick();
    req_valid = oh;
    req_op[r] = op;
    if (r == 0) begin req_a[31:0] = a;  req_b[31:0] = b;  end
    else        begin req_a[63:32] = a; req_b[63:32] = b; end
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(oh));
    tick();
    req_valid = 2'b00;
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    req_op = 2'($urandom);
    @(negedge clk);
    chk({tag, ".exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".exec_busy"}, 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(oh));
    chk({tag, ".rsp_res"}, rsp_res, exp);
    chk_ovf({tag, ".rsp_ovf"}, eovf);
    for (int k = 0; k < hold; k++) begin
      rsp_ready = ~oh;
      req_valid = 2'b11;
      tick();
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'(oh));
      chk({tag, ".hold_res"}, rsp_res, exp);
      chk({tag, ".hold_busy"}, 32'(busy), 32'd1);
      chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    tick();
    req_valid = 2'b00;
    rsp_ready = oh;
    tick();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rexp;
    logic        rop, rovf;
    longint      sa, sb, st;
    int          rr, cyc;
    logic [1:0]  oh;

    vt[0] = '{0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 0};
    vt[1] = '{1, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 5};
    vt[2] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 0};
    vt[3] = '{1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1};
    vt[4] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 0};
    vt[5] = '{0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 2};
    vt[6] = '{0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, 0};

    rst_n = 1'b0;
    req_valid = 2'b00; req_op = 2'b00; rsp_ready = 2'b00;
    req_a = '0; req_b = '0;
    tick();
    @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_res", rsp_res, 32'd0);
    chk("reset.req_ready", 32'(req_ready), 32'd0);
    chk_ovf("reset.rsp_ovf", 1'b0);
    tick();
    rst_n = 1'b1;

    foreach (vt[i])
      run_op($sformatf("tbl%0d", i), vt[i].r, vt[i].a, vt[i].b, vt[i].op, vt[i].exp, vt[i].ovf, vt[i].hold);

    for (int i = 0; i < 24; i++) begin
      rr  = int'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      rop = 1'($urandom_range(0, 1));
      rexp = rop ? ra - rb : ra + rb;
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      st = rop ? sa - sb : sa + sb;
      rovf = (st > 64'sd2147483647) || (st < -64'sd2147483648);
      run_op($sformatf("rnd%0d", i), rr, ra, rb, rop, rexp, rovf, int'($urandom_range(0, 2)));
    end

    // Round robin from reset with both requesters always valid.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_a = {32'd100, 32'd10};
    req_b = {32'd1, 32'd20};
    req_op = 2'b10;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      oh = 2'b01 << (i % 2);
      cyc = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && cyc < 8) begin @(negedge clk); cyc++; end
      chk($sformatf("rr%0d.grant", i), 32'(req_ready), 32'(oh));
      cyc = 0;
      @(negedge clk);
      while (rsp_valid == 2'b00 && cyc < 8) begin @(negedge clk); cyc++; end
      chk($sformatf("rr%0d.rsp_valid", i), 32'(rsp_valid), 32'(oh));
      chk($sformatf("rr%0d.rsp_res", i), rsp_res, (i % 2 == 0) ? 32'd30 : 32'd99);
    end
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("rr.idle_busy", 32'(busy), 32'd0);

    // Reset during EXEC: in-flight command dropped, round-robin pointer restored.
    run_op("pre_rst", 0, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 0);
    tick();
    req_valid = 2'b01;
    req_a[31:0] = 32'h1234;
    req_b[31:0] = 32'h1;
    req_op[0] = 1'b0;
    @(negedge clk);
    chk("rst_exec.req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("rst_exec.busy_before", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_exec.busy", 32'(busy), 32'd0);
    chk("rst_exec.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_exec.rsp_res", rsp_res, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_exec.no_rsp%0d", k), 32'(rsp_valid), 32'd0);
    end
    tick();
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_exec.next_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    cyc = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && cyc < 8) begin @(negedge clk); cyc++; end
    chk("rst_exec.after_valid", 32'(rsp_valid), 32'd1);
    tick();
    rsp_ready = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 supported.
REQ-002 Port: clk  input  1  rising-edge clock, the block's only clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req_valid  input  2  per-requester command valid; bit i = requester i.
REQ-005 Port: req_ready  output  2  per-requester command accept.
REQ-006 Port: req_a  input  64  operand A; bits [32i+31:32i] belong to requester i.
REQ-007 Port: req_b  input  64  operand B; same packing.
REQ-008 Port: req_op  input  2  bit i: 0 = add (A+B), 1 = subtract (A-B).
REQ-009 Port: rsp_valid  output  2  per-requester result valid.
REQ-010 Port: rsp_ready  input  2  per-requester result accept.
REQ-011 Port: rsp_res  output  32  result, shared by both requesters; qualified by rsp_valid.
REQ-012 Port: busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 The block SHALL share a single 32-bit add/sub datapath between two requesters.
REQ-014 FSM states: IDLE, EXEC, RESP; no other encodings reachable.
REQ-015 IDLE: no req_valid -> stay; otherwise grant, latch a/b/op/grant index, go EXEC.
REQ-016 req_ready[i] SHALL be combinational: high only in IDLE with grant = i; a transfer occurs when valid & ready.
REQ-017 Arbitration: one valid -> grant it; both valid -> grant the requester not equal to last_grant (round-robin).
REQ-018 last_grant SHALL update at the transfer; a lone requester may be granted back-to-back.
REQ-019 EXEC: lasts exactly one cycle; the datapath output is registered into rsp_res; go RESP.
REQ-020 Subtraction SHALL be A + ~B + 1, modulo 2^32; carry-out discarded; add wraps likewise.
REQ-021 RESP: rsp_valid[grant] = 1, other bit 0; rsp_res stable; hold until rsp_ready[grant], then go IDLE in the next cycle.
REQ-022 rsp_ready on the non-granted bit SHALL be ignored; req_valid during EXEC/RESP SHALL be ignored (req_ready = 0).
REQ-023 Latency: transfer cycle T -> rsp_valid high at T+2; minimum issue interval 3 cycles.
REQ-024 Operands SHALL be sampled only at the transfer; later input changes do not alter the result.

Reset
REQ-025 Asynchronous assertion of rst_n SHALL force: state IDLE, last_grant = 1, rsp_valid = 0, rsp_res = 0, busy = 0.
REQ-026 Reset mid-operation SHALL discard the in-flight command with no response; deassertion is synchronised externally.

Configuration
REQ-027 Macro ADDSUB_ARB_OVF_EN defined: an extra output rsp_ovf (1 bit) SHALL carry signed overflow, registered with rsp_res, reset 0.
REQ-028 Overflow definition: add: sign(A) = sign(B) != sign(R); sub: sign(A) != sign(B) and sign(R) != sign(A).
REQ-029 Macro undefined: no rsp_ovf port and no overflow logic; all other behaviour is identical.

Structure
REQ-030 Shared package addsub_pkg SHALL hold: state enum (IDLE/EXEC/RESP), OP_ADD = 0 / OP_SUB = 1, DATA_W.
REQ-031 One sub-module: the combinational sub_add_32bit instance, driven from the latched operands with alu_op = latched op.
REQ-032 Arbiter, FSM, and result/overflow registers SHALL live in addsub_arbiter itself.

Verification
REQ-033 Req0 add 0x00000005 + 0x00000003 -> ready0 at T; rsp_valid = 01 at T+2; rsp_res = 0x00000008.
REQ-034 Req1 sub 0x00000000 - 0x00000001 -> rsp_res = 0xFFFFFFFF; with ADDSUB_ARB_OVF_EN, rsp_ovf = 0.
REQ-035 Both valid continuously from reset -> grant order 0,1,0,1; each response on the matching rsp_valid bit.
REQ-036 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_res stable, busy = 1, req_ready = 00 throughout.
REQ-037 Add 0x7FFFFFFF + 0x00000001 -> rsp_res = 0x80000000, rsp_ovf = 1 (macro on); no port (macro off).
REQ-038 rst_n low during EXEC -> immediately busy = 0, rsp_valid = 00; no response after release; next grant goes to req0.
